// File: rtl/dmem_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : dmem_ctrl
// Description : Data-memory controller between the LSU/MEM stage and an
//               inferred block RAM. Valid/ready request/response handshake,
//               registered read, byte-lane write enables, range and funct3
//               fault detection.
// Options     : DMEM_MISALIGN_CHK_EN - when defined, misaligned halfword and
//               word accesses take the error path instead of ignoring the
//               low offset bits.
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_ctrl #(
    parameter int               WIDTH     = 32,
    parameter int               MEM_DEPTH = 1024,
    parameter logic [WIDTH-1:0] BASE_ADDR = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_we,
    input  logic [2:0]       req_funct3,
    input  logic [WIDTH-1:0] req_addr,
    input  logic [WIDTH-1:0] req_wdata,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_rdata,
    output logic             rsp_err
);

    localparam int AW = $clog2(MEM_DEPTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [WIDTH-1:0] mem [MEM_DEPTH];
    logic [WIDTH-1:0] ram_rdata_q;

    logic [2:0]       funct3_q,    funct3_d;
    logic [1:0]       offset_q,    offset_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic             rsp_err_q,   rsp_err_d;
    logic [WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;

    logic [WIDTH-1:0] rel_addr;
    logic [AW-1:0]    word_idx;
    logic             in_range;
    logic             funct3_ok;
    logic             misaligned;
    logic             req_err;
    logic             hs;
    logic [3:0]       byte_we;
    logic [WIDTH-1:0] wdata_rep;
    logic [7:0]       sel_byte;
    logic [15:0]      sel_half;
    logic [WIDTH-1:0] load_fmt;

    // Only IDLE accepts requests, and nothing is accepted while in reset.
    assign req_ready = rst && (state_q == IDLE);
    assign hs        = req_valid && req_ready;

    assign rsp_valid = rsp_valid_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_rdata = rsp_rdata_q;

    // Decode the incoming request: word index, fault detection, lane enables.
    always_comb begin
        rel_addr = req_addr - BASE_ADDR;
        // Addresses below BASE_ADDR wrap to large values and fail this test too.
        in_range = (rel_addr[WIDTH-1:AW+2] == '0);
        word_idx = rel_addr[AW+1:2];

        if (req_we) begin
            funct3_ok = (req_funct3 == 3'b000) || (req_funct3 == 3'b001) ||
                        (req_funct3 == 3'b010);
        end else begin
            funct3_ok = !((req_funct3 == 3'b011) || (req_funct3 == 3'b110) ||
                          (req_funct3 == 3'b111));
        end

`ifdef DMEM_MISALIGN_CHK_EN
        misaligned = ((req_funct3[1:0] == 2'b01) && rel_addr[0]) ||
                     ((req_funct3[1:0] == 2'b10) && (rel_addr[1:0] != 2'b00));
`else
        misaligned = 1'b0;
`endif

        req_err = !in_range || !funct3_ok || misaligned;

        byte_we   = 4'b1111;
        wdata_rep = req_wdata;
        case (req_funct3[1:0])
            2'b00: begin
                byte_we   = 4'b0001 << rel_addr[1:0];
                wdata_rep = {4{req_wdata[7:0]}};
            end
            2'b01: begin
                byte_we   = rel_addr[1] ? 4'b1100 : 4'b0011;
                wdata_rep = {2{req_wdata[15:0]}};
            end
            default: begin
                byte_we   = 4'b1111;
                wdata_rep = req_wdata;
            end
        endcase
    end

    // Store commits on the handshake edge so a following load sees it.
    always_ff @(posedge clk) begin
        if (hs && req_we && !req_err) begin
            for (int b = 0; b < 4; b++) begin
                if (byte_we[b]) begin
                    mem[word_idx][8*b +: 8] <= wdata_rep[8*b +: 8];
                end
            end
        end
    end

    // Synchronous BRAM read, launched on the request handshake.
    always_ff @(posedge clk) begin
        if (hs) begin
            ram_rdata_q <= mem[word_idx];
        end
    end

    // Pick the addressed byte/half from the RAM word and extend it.
    always_comb begin
        sel_byte = ram_rdata_q[8*offset_q +: 8];
        sel_half = offset_q[1] ? ram_rdata_q[31:16] : ram_rdata_q[15:0];
        case (funct3_q[1:0])
            2'b00:   load_fmt = funct3_q[2] ? {{(WIDTH-8){1'b0}}, sel_byte}
                                            : {{(WIDTH-8){sel_byte[7]}}, sel_byte};
            2'b01:   load_fmt = funct3_q[2] ? {{(WIDTH-16){1'b0}}, sel_half}
                                            : {{(WIDTH-16){sel_half[15]}}, sel_half};
            default: load_fmt = ram_rdata_q;
        endcase
    end

    // Next-state and response register logic.
    always_comb begin
        state_d     = state_q;
        funct3_d    = funct3_q;
        offset_d    = offset_q;
        rsp_valid_d = rsp_valid_q;
        rsp_err_d   = rsp_err_q;
        rsp_rdata_d = rsp_rdata_q;

        case (state_q)
            IDLE: begin
                if (hs) begin
                    funct3_d = req_funct3;
                    offset_d = rel_addr[1:0];
                    if (req_err || req_we) begin
                        state_d     = RESP;
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = req_err;
                        rsp_rdata_d = '0;
                    end else begin
                        state_d = RD;
                    end
                end
            end
            RD: begin
                state_d     = RESP;
                rsp_valid_d = 1'b1;
                rsp_err_d   = 1'b0;
                rsp_rdata_d = load_fmt;
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d     = IDLE;
                    rsp_valid_d = 1'b0;
                    rsp_err_d   = 1'b0;
                    rsp_rdata_d = '0;
                end
            end
            default: begin
                state_d     = IDLE;
                rsp_valid_d = 1'b0;
                rsp_err_d   = 1'b0;
                rsp_rdata_d = '0;
            end
        endcase
    end

    // State and response registers; reset drops any pending response.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= IDLE;
            funct3_q    <= 3'b000;
            offset_q    <= 2'b00;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            funct3_q    <= funct3_d;
            offset_q    <= offset_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

endmodule
`default_nettype wire

// File: doc/dmem_ctrl.md
Name: dmem_ctrl

Overview:
- Parametrised data-memory controller; successor to the core's single-cycle data RAM.
- Sits between the LSU/MEM stage and an inferred block RAM.
- Adds a valid/ready request/response handshake, registered read latency, byte-lane write enables and a configurable depth.
- Flags out-of-range accesses and illegal funct3 values with an error bit.

Parameters:
- WIDTH, 32: data/address width (XLEN); only 32 is supported.
- MEM_DEPTH, 1024: number of 32-bit words; power of two, 16..65536.
- BASE_ADDR, 32'h0000_0000: byte address of word 0; must be MEM_DEPTH*4-aligned.

Ports:
- clk  in  1  clock; all logic on posedge.
- rst  in  1  synchronous reset, active-low.
- req_valid  in  1  request present.
- req_ready  out  1  controller accepts a request this cycle.
- req_we  in  1  0 = load, 1 = store.
- req_funct3  in  3  RV32I width/sign code (LB/LH/LW/LBU/LHU, SB/SH/SW).
- req_addr  in  WIDTH  byte address.
- req_wdata  in  WIDTH  store data, right-aligned (byte in [7:0], half in [15:0]).
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer accepts the response.
- rsp_rdata  out  WIDTH  load result, sign/zero-extended; 0 for stores and errors.
- rsp_err  out  1  access faulted.

Behaviour:
- Reset (rst==0 at posedge): state=IDLE, rsp_valid=0, rsp_rdata=0, rsp_err=0.
- req_ready=0 while rst==0. Memory contents are not cleared.
- A reset mid-transaction aborts it. A store already committed stays committed; a pending response is dropped.
- FSM states: IDLE, RD, RESP.
- req_ready = (state==IDLE). One outstanding request only.
- Handshake: req_valid && req_ready at a posedge. Request fields are captured into internal registers; inputs may change afterwards.
- Word index = (req_addr - BASE_ADDR) >> 2. Byte offset = req_addr[1:0].
- Error conditions, checked at handshake:
  - Address outside [BASE_ADDR, BASE_ADDR + 4*MEM_DEPTH).
  - Load funct3 in {011, 110, 111}.
  - Store funct3 not in {000, 001, 010}.
- Error path: IDLE -> RESP. rsp_err=1, rsp_rdata=0, no memory write.
- Store path, IDLE -> RESP:
  - Write commits on the handshake edge using per-byte write enables.
  - SB: lane = offset; data replicated req_wdata[7:0].
  - SH: lanes {1,0} if offset[1]==0, else {3,2}; data replicated req_wdata[15:0].
  - SW: all four lanes.
  - rsp_valid=1 on the following cycle; rsp_err=0.
- Load path, IDLE -> RD -> RESP:
  - RAM read is registered (synchronous BRAM read).
  - RD formats the word: LB/LBU select lane = offset; LH/LHU select half = offset[1]; sign-extend for LB/LH, zero-extend for LBU/LHU.
  - Result registered into rsp_rdata at RD -> RESP.
  - rsp_valid rises 2 cycles after the handshake.
- RESP:
  - Holds rsp_valid, rsp_rdata and rsp_err stable until rsp_ready==1 at a posedge, then goes to IDLE.
  - req_ready is 0 in RESP; no request is accepted in the same cycle as the response handshake.
- Back-to-back store then load to the same word: the load returns the newly written data, because the write commits before the RD read.
- Alignment: without the optional feature, misaligned halfwords and words are not faulted. SH at offset 1 behaves as offset 0; SW/LW ignore offset.

Optional Feature:
- Macro: DMEM_MISALIGN_CHK_EN.
- Defined: these accesses take the error path with rsp_err=1 and no write:
  - LH/LHU/SH with offset[0]==1.
  - LW/SW with offset != 0.
- Undefined: no alignment check; offset bits are ignored as described in Behaviour.

Test Plan:
- Reset: hold rst=0 for 3 cycles with req_valid=1 -> req_ready=0, rsp_valid=0, rsp_rdata=0; after release req_ready=1 next cycle.
- SW 0xDEADBEEF @0x10, then LW @0x10 -> store rsp_valid 1 cycle after handshake with rsp_err=0; load rsp_rdata=0xDEADBEEF 2 cycles after handshake.
- SB 0x80 @0x13, then LB @0x13 and LBU @0x13 -> 0xFFFFFF80 and 0x00000080. LW @0x10 -> 0x80ADBEEF.
- SH 0x8001 @0x12, then LH @0x12 and LHU @0x12 -> 0xFFFF8001 and 0x00008001. Hold rsp_ready=0 for 5 cycles -> response held stable, req_ready=0.
- LW @(BASE_ADDR + 4*MEM_DEPTH) = 0x1000 with defaults -> rsp_err=1, rsp_rdata=0. Load funct3=011 @0x0 -> rsp_err=1.
- With DMEM_MISALIGN_CHK_EN: SW 0x12345678 @0x21 -> rsp_err=1, word @0x20 unchanged. Without the macro -> word @0x20 = 0x12345678, rsp_err=0.
